// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg
// Shared definitions for the ADC capture controller and its decimation divider.
// Contents:
//   state_t          - capture FSM state encoding
//   CFG_* indices    - bit positions of {dith, rand_, pga} inside the cfg word
//   DEC_W / CNT_W    - decimation divisor and sample/overflow counter widths
//   DATA_W           - ADC sample width
package adc_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        SETTLE,
        CAPTURE,
        DRAIN
    } state_t;

    localparam int CFG_W    = 3;
    localparam int CFG_DITH = 2;
    localparam int CFG_RAND = 1;
    localparam int CFG_PGA  = 0;

    localparam int DEC_W  = 16;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 16;

endpackage

// File: rtl/adc_decim_tick.sv
// adc_decim_tick
// Decimation divider: while enabled, counts 0..divisor-1 and asserts tick in
// the cycle the count sits at its terminal value. A divisor of 0 behaves as 1
// (tick every enabled cycle).
// Ports:
//   clkouta  in   ADC output clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   synchronous counter clear (frame start)
//   enable   in   count enable (capture phase)
//   divisor  in   decimation divisor, held stable during a frame
//   tick     out  combinational terminal-count strobe
module adc_decim_tick
    import adc_capture_ctrl_pkg::*;
(
    input  logic             clkouta,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DEC_W-1:0] divisor,
    output logic             tick
);

    logic [DEC_W-1:0] cnt;
    logic [DEC_W-1:0] last;

    assign last = (divisor == '0) ? '0 : divisor - DEC_W'(1);
    assign tick = enable && (cnt == last);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + DEC_W'(1);
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Configures the ADC control pins, waits for the converter to settle, then
// captures a decimated frame of FRAME_LEN samples into a valid/ready output
// register. Samples arriving while the output is stalled are dropped and
// flagged.
// Optional feature: define ADC_OVF_COUNT_EN to add the ovf_cnt output, a
// saturating per-frame count of overflowing sample ticks.
// Ports:
//   clkouta            in   ADC output clock (sole clock)
//   rst_n              in   asynchronous active-low reset
//   start / abort      in   single-cycle frame request / frame termination
//   cfg                in   requested pins {dith, rand_, pga}, latched on start
//   dec_div            in   decimation divisor (0 acts as 1), latched on start
//   adc_data, adc_ofa  in   ADC sample bus and overflow indicator
//   dith, rand_, pga   out  ADC control pins
//   out_data/out_valid out  captured sample, held until out_ready
//   out_ready          in   downstream accept
//   busy               out  high outside IDLE
//   frame_done         out  one-cycle pulse on frame completion
//   ovf_flag, lost     out  sticky overflow / dropped-sample flags
//   ovf_cnt            out  overflow tick count (ADC_OVF_COUNT_EN only)
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int FRAME_LEN  = 256,
    parameter int SETTLE_CYC = 64
) (
    input  logic              clkouta,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CFG_W-1:0]  cfg,
    input  logic [DEC_W-1:0]  dec_div,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_ofa,
    output logic              dith,
    output logic              rand_,
    output logic              pga,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf_flag,
    output logic              lost
`ifdef ADC_OVF_COUNT_EN
    ,
    output logic [CNT_W-1:0]  ovf_cnt
`endif
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CFG_W-1:0]  cfg_q;
    logic [DEC_W-1:0]  dec_q;
    logic [CNT_W-1:0]  sample_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              tick;
    logic              start_go;
    logic              abort_go;
    logic              live_tick;
    logic              take;
    logic              drop;

    // A start is only honoured from IDLE, and a coincident abort suppresses it.
    assign start_go  = (state == IDLE) && start && !abort;
    assign abort_go  = (state != IDLE) && abort;
    // A tick in the abort cycle is discarded: the frame is already over.
    assign live_tick = tick && !abort;
    assign take      = live_tick && (!out_valid || out_ready);
    assign drop      = live_tick && out_valid && !out_ready;
    assign busy      = (state != IDLE);

    adc_decim_tick u_decim (
        .clkouta (clkouta),
        .rst_n   (rst_n),
        .clear   (start_go),
        .enable  (state == CAPTURE),
        .divisor (dec_q),
        .tick    (tick)
    );

    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (start_go) state_nxt = CONFIG;
            CONFIG:  state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
            CAPTURE: if (take && (sample_cnt == FRAME_LAST)) state_nxt = DRAIN;
            DRAIN: begin
                if (!out_valid) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_go) begin
            state_nxt  = IDLE;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= '0;
            dec_q      <= '0;
            dith       <= 1'b0;
            rand_      <= 1'b0;
            pga        <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
            settle_cnt <= '0;
            ovf_flag   <= 1'b0;
            lost       <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;

            if (start_go) begin
                cfg_q      <= cfg;
                dec_q      <= dec_div;
                sample_cnt <= '0;
                ovf_flag   <= 1'b0;
                lost       <= 1'b0;
            end

            // Pins change only at the end of CONFIG and then hold across
            // frames; an abort during CONFIG leaves the old pin values.
            if ((state == CONFIG) && !abort) begin
                dith  <= cfg_q[CFG_DITH];
                rand_ <= cfg_q[CFG_RAND];
                pga   <= cfg_q[CFG_PGA];
            end

            if (abort_go) begin
                out_valid <= 1'b0;
            end else if (take) begin
                out_data   <= adc_data;
                out_valid  <= 1'b1;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                lost <= 1'b1;
            end
            if (live_tick && adc_ofa) begin
                ovf_flag <= 1'b1;
            end
        end
    end

`ifdef ADC_OVF_COUNT_EN
    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (start_go) begin
            ovf_cnt <= '0;
        end else if (live_tick && adc_ofa && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl
// Directed bench for adc_capture_ctrl with FRAME_LEN=8, SETTLE_CYC=4.
// Each task drives one scenario and compares outputs against hand-computed
// cycle positions measured from the start pulse. rel counts clock edges
// since start was driven; a sample taken at edge n carries the adc_data
// value driven just before it (DATA_BASE + absolute cycle index).
// Edge positions: CONFIG at rel 1, SETTLE at rel 2..5, CAPTURE from rel 6,
// tick k at edge 6 + k*dec (dec 0 acts as 1).
module tb_adc_capture_ctrl;

    localparam int FRAME_LEN  = 8;
    localparam int SETTLE_CYC = 4;
    localparam logic [15:0] DATA_BASE = 16'h5A00;

    logic        clkouta = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  cfg;
    logic [15:0] dec_div;
    logic [15:0] adc_data;
    logic        adc_ofa;
    logic        dith;
    logic        rand_;
    logic        pga;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic        ovf_flag;
    logic        lost;
`ifdef ADC_OVF_COUNT_EN
    logic [15:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    int cyc0 = 0;
    int new_cnt, done_cnt, first_new_rel, last_new_rel, done_rel;
    int data_bad, gap_bad, exp_gap;

    always #5 clkouta = ~clkouta;

    adc_capture_ctrl #(
        .FRAME_LEN  (FRAME_LEN),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clkouta    (clkouta),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg        (cfg),
        .dec_div    (dec_div),
        .adc_data   (adc_data),
        .adc_ofa    (adc_ofa),
        .dith       (dith),
        .rand_      (rand_),
        .pga        (pga),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf_flag   (ovf_flag),
        .lost       (lost)
`ifdef ADC_OVF_COUNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // Advance one edge, observe 1 time unit later, record newly loaded
    // samples (data, spacing) and frame_done pulses, then present new data.
    task automatic step();
        logic        v_before;
        logic        r_before;
        logic [15:0] exp_d;
        v_before = out_valid;
        r_before = out_ready;
        @(posedge clkouta);
        #1;
        cyc++;
        rel++;
        if (out_valid === 1'b1 && (!v_before || r_before)) begin
            exp_d = DATA_BASE + 16'(cyc - 1);
            if (out_data !== exp_d) data_bad++;
            if (first_new_rel < 0) first_new_rel = rel;
            if (exp_gap > 0 && last_new_rel >= 0 && (rel - last_new_rel) != exp_gap) gap_bad++;
            last_new_rel = rel;
            new_cnt++;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (done_rel < 0) done_rel = rel;
        end
        adc_data = DATA_BASE + 16'(cyc);
    endtask

    task automatic start_frame(input logic [2:0] c, input logic [15:0] d);
        cfg           = c;
        dec_div       = d;
        start         = 1'b1;
        rel           = 0;
        cyc0          = cyc;
        new_cnt       = 0;
        done_cnt      = 0;
        first_new_rel = -1;
        last_new_rel  = -1;
        done_rel      = -1;
        data_bad      = 0;
        gap_bad       = 0;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done();
        while (done_rel < 0 && rel < 200) step();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg = 3'b111; dec_div = 16'd0;
        adc_data = DATA_BASE; adc_ofa = 1'b0; out_ready = 1'b0; exp_gap = 0;
        repeat (3) @(posedge clkouta);
        #1;
        checks++; if ({dith, rand_, pga} !== 3'b000) begin errors++; $display("FAIL reset_pins: got %b want 000", {dith, rand_, pga}); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if ({out_valid, busy, frame_done, ovf_flag, lost} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {out_valid, busy, frame_done, ovf_flag, lost}); end
`ifdef ADC_OVF_COUNT_EN
        checks++; if (ovf_cnt !== 16'h0000) begin errors++; $display("FAIL reset_ovf_cnt: got %0d want 0", ovf_cnt); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        exp_gap   = 4;
        out_ready = 1'b1;
        start_frame(3'b101, 16'd4);
        step();
        checks++; if ({dith, rand_, pga} !== 3'b101) begin errors++; $display("FAIL basic_pins_after_config: got %b want 101", {dith, rand_, pga}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        // A start mid-frame (with different cfg) must be ignored.
        while (done_rel < 0 && rel < 200) begin
            start = (rel == 20);
            cfg   = (rel == 20) ? 3'b010 : 3'b101;
            step();
        end
        start = 1'b0;
        repeat (3) step();
        checks++; if (first_new_rel !== 10) begin errors++; $display("FAIL basic_first_sample: got rel %0d want 10", first_new_rel); end
        checks++; if (new_cnt !== 8) begin errors++; $display("FAIL basic_sample_count: got %0d want 8", new_cnt); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL basic_spacing: got %0d bad gaps want 0", gap_bad); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL basic_data: got %0d bad samples want 0", data_bad); end
        checks++; if (done_rel !== 39) begin errors++; $display("FAIL basic_done_time: got rel %0d want 39 (-1 = timeout)", done_rel); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if ({lost, busy} !== 2'b00) begin errors++; $display("FAIL basic_lost_busy: got %b want 00", {lost, busy}); end
        checks++; if ({dith, rand_, pga} !== 3'b101) begin errors++; $display("FAIL basic_pins_hold: got %b want 101", {dith, rand_, pga}); end
    endtask

    task automatic test_dec0();
        exp_gap   = 1;
        out_ready = 1'b1;
        start_frame(3'b000, 16'd0);
        run_to_done();
        checks++; if (first_new_rel !== 7) begin errors++; $display("FAIL dec0_first_sample: got rel %0d want 7", first_new_rel); end
        checks++; if (new_cnt !== 8) begin errors++; $display("FAIL dec0_sample_count: got %0d want 8", new_cnt); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL dec0_every_cycle: got %0d bad gaps want 0", gap_bad); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL dec0_data: got %0d bad samples want 0", data_bad); end
        checks++; if (done_rel !== 15) begin errors++; $display("FAIL dec0_done_time: got rel %0d want 15 (-1 = timeout)", done_rel); end
        checks++; if ({dith, rand_, pga} !== 3'b000) begin errors++; $display("FAIL dec0_pins: got %b want 000", {dith, rand_, pga}); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        exp_gap   = 0;
        out_ready = 1'b0;
        start_frame(3'b110, 16'd1);
        while (rel < 7) step();
        checks++; if ({out_valid, lost} !== 2'b10) begin errors++; $display("FAIL bp_first_tick: got valid/lost %b want 10", {out_valid, lost}); end
        while (rel < 9) step();
        held = DATA_BASE + 16'(cyc0 + 6);
        checks++; if (out_data !== held) begin errors++; $display("FAIL bp_held_data: got %h want %h", out_data, held); end
        checks++; if ({out_valid, lost} !== 2'b11) begin errors++; $display("FAIL bp_dropped: got valid/lost %b want 11", {out_valid, lost}); end
        out_ready = 1'b1;
        run_to_done();
        // Count stayed at 1 across the drops, so 7 more ticks (edges 10..16).
        checks++; if (done_rel !== 17) begin errors++; $display("FAIL bp_done_time: got rel %0d want 17 (-1 = timeout)", done_rel); end
        checks++; if (new_cnt !== 8) begin errors++; $display("FAIL bp_sample_count: got %0d want 8", new_cnt); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL bp_data: got %0d bad samples want 0", data_bad); end
        checks++; if (lost !== 1'b1) begin errors++; $display("FAIL bp_lost_sticky: got %b want 1", lost); end
    endtask

    task automatic test_ovf();
        exp_gap   = 4;
        out_ready = 1'b1;
        start_frame(3'b100, 16'd4);
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL ovf_lost_cleared_on_start: got %b want 0", lost); end
        // adc_ofa on edges 12 (not a tick), 14 (tick 2), 26 (tick 5).
        while (done_rel < 0 && rel < 200) begin
            if (rel == 13) begin
                checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_non_tick_ignored: got %b want 0", ovf_flag); end
            end
            adc_ofa = (rel == 11) || (rel == 13) || (rel == 25);
            step();
        end
        adc_ofa = 1'b0;
        repeat (3) step();
        checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_flag); end
        checks++; if (new_cnt !== 8) begin errors++; $display("FAIL ovf_sample_count: got %0d want 8", new_cnt); end
`ifdef ADC_OVF_COUNT_EN
        checks++; if (ovf_cnt !== 16'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", ovf_cnt); end
`endif
    endtask

    task automatic test_abort();
        exp_gap   = 0;
        out_ready = 1'b0;
        start_frame(3'b011, 16'd2);
        checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL abort_ovf_cleared_on_start: got %b want 0", ovf_flag); end
        while (rel < 3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_settle_idle: got busy %b want 0", busy); end
        // abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy %b want 0", busy); end
        checks++; if ({dith, rand_, pga} !== 3'b011) begin errors++; $display("FAIL abort_pins_retained: got %b want 011", {dith, rand_, pga}); end
        start_frame(3'b011, 16'd1);
        while (rel < 7) step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_capture_setup: got valid %b want 1", out_valid); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL abort_capture_idle: got valid/busy %b want 00", {out_valid, busy}); end
        repeat (10) step();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_frame_done: got %0d pulses want 0", done_cnt); end
        checks++; if ({dith, rand_, pga} !== 3'b011) begin errors++; $display("FAIL abort_pins_after_capture: got %b want 011", {dith, rand_, pga}); end
    endtask

    task automatic test_reset_mid();
        exp_gap   = 0;
        out_ready = 1'b0;
        start_frame(3'b101, 16'd1);
        while (rel < 9) step();
        checks++; if ({busy, out_valid, lost} !== 3'b111) begin errors++; $display("FAIL rmid_setup: got busy/valid/lost %b want 111", {busy, out_valid, lost}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({dith, rand_, pga} !== 3'b000) begin errors++; $display("FAIL rmid_pins: got %b want 000", {dith, rand_, pga}); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rmid_out_data: got %h want 0000", out_data); end
        checks++; if ({out_valid, busy, frame_done, ovf_flag, lost} !== 5'b0) begin errors++; $display("FAIL rmid_flags: got %b want 00000", {out_valid, busy, frame_done, ovf_flag, lost}); end
        step();
        step();
        rst_n = 1'b1;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rmid_no_frame_done: got %0d pulses want 0", done_cnt); end
        exp_gap   = 1;
        out_ready = 1'b1;
        start_frame(3'b110, 16'd0);
        run_to_done();
        checks++; if (new_cnt !== 8) begin errors++; $display("FAIL rmid_new_frame_count: got %0d want 8", new_cnt); end
        checks++; if (done_rel !== 15) begin errors++; $display("FAIL rmid_new_frame_done: got rel %0d want 15 (-1 = timeout)", done_rel); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rmid_done_count: got %0d want 1", done_cnt); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL rmid_data: got %0d bad samples want 0", data_bad); end
        checks++; if ({dith, rand_, pga} !== 3'b110) begin errors++; $display("FAIL rmid_pins: got %b want 110", {dith, rand_, pga}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dec0();
        test_backpressure();
        test_ovf();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
